// File: rtl/rr_reg_arbiter.sv
// Round-robin ownership arbiter for one shared W-bit register.
// Four requesters ask for ownership, write while granted and then release.
// A dead RELEASE cycle always separates two grants, so grants never overlap.
// Optional feature macro: HOLD_TIMEOUT_EN (forces release after MAX_HOLD
// cycles in GRANT and pulses timeout). Without it an owner may hold forever.
module rr_reg_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [3:0]     rel,
  input  logic [3:0]     wr_en,
  input  logic [4*W-1:0] wr_data,
  output logic [3:0]     gnt,
  output logic [1:0]     gnt_id,
  output logic           busy,
  output logic [W-1:0]   q,
  output logic           timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [3:0]     gnt_next;
  logic [1:0]     gnt_id_next;
  logic           busy_next;
  logic [1:0]     last, last_next;
  logic [W-1:0]   q_next;
  logic [1:0]     sel;
  logic           sel_valid;
  logic           owner_done;
  logic           force_rel;

  // The current owner gives up the register by pulsing rel or dropping req.
  assign owner_done = rel[gnt_id] | ~req[gnt_id];

`ifdef HOLD_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_cnt;

  assign force_rel = (hold_cnt == HW'(MAX_HOLD - 1));

  // Hold counter: sits at zero outside GRANT, counts cycles spent in GRANT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  // Timeout pulse covers only the RELEASE cycle caused by a forced release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && force_rel && !owner_done;
    end
  end
`else
  // No hold limit: MAX_HOLD is never negative, so this is constant zero.
  assign force_rel = (MAX_HOLD < 0);
  assign timeout   = 1'b0;
`endif

  // Round-robin pick: first set request scanning upward from last+1, wrapping.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!sel_valid && req[last + 2'(k)]) begin
        sel       = last + 2'(k);
        sel_valid = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the ownership sequencer.
  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    gnt_id_next = gnt_id;
    busy_next   = busy;
    last_next   = last;
    q_next      = q;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          state_next  = GRANT;
          gnt_next    = 4'b0001 << sel;
          gnt_id_next = sel;
          busy_next   = 1'b1;
          last_next   = sel;
        end
      end
      GRANT: begin
        if (wr_en[gnt_id]) begin
          q_next = wr_data[gnt_id*W +: W];
        end
        if (owner_done || force_rel) begin
          state_next = RELEASE;
          gnt_next   = '0;
          busy_next  = 1'b0;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, grant, pointer and shared register flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      last   <= 2'd3;
      q      <= '0;
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      gnt_id <= gnt_id_next;
      busy   <= busy_next;
      last   <= last_next;
      q      <= q_next;
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level ownership model.
module tb_rr_reg_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [3:0]     rel;
  logic [3:0]     wr_en;
  logic [4*W-1:0] wr_data;
  logic [3:0]     gnt;
  logic [1:0]     gnt_id;
  logic           busy;
  logic [W-1:0]   q;
  logic           timeout;

  int checks;
  int errors;

  // Reference model state: who owns the register, dead-cycle flag, pointer.
  int           m_owner;
  bit           m_dead;
  int           m_last;
  int           m_held;
  bit           m_to;
  logic [W-1:0] m_q;

  rr_reg_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rel     (rel),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .q       (q),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = '0; rel = '0; wr_en = '0; wr_data = '0;
  endtask

  task automatic pulse_reset;
    clear_inputs();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic settle;
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic model_reset;
    m_owner = -1; m_dead = 0; m_last = 3; m_held = 0; m_to = 0; m_q = '0;
  endtask

  // One clock edge of the ownership rules, applied to the held inputs.
  task automatic model_step;
    bit done;
    bit timed;
    m_to = 0;
    if (m_dead) begin
      m_dead = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && req[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
        end
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      if (wr_en[m_owner]) m_q = wr_data[m_owner*W +: W];
      done  = rel[m_owner] || !req[m_owner];
`ifdef HOLD_TIMEOUT_EN
      timed = (m_held >= MAX_HOLD);
`else
      timed = 0;
`endif
      if (done || timed) begin
        m_owner = -1;
        m_dead  = 1;
        m_to    = timed && !done;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    #12;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: gnt=%b busy=%b q=%h timeout=%b gnt_id=%0d, expected 0000/0/00/0/0",
               gnt, busy, q, timeout, gnt_id);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_grant;
    req = 4'b0100;
    tick();
    wr_en = 4'b0100;
    wr_data[2*W +: W] = 8'h5A;
    tick();
    checks++;
    if (gnt !== 4'b0100 || q !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL mid_grant_setup: gnt=%b q=%h, expected 0100/5a", gnt, q);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: gnt=%b busy=%b q=%h, expected 0000/0/00", gnt, busy, q);
    end
    #1;
    reset = 1'b0;
    clear_inputs();
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL first_after_reset: gnt=%b, expected 0001", gnt);
    end
    settle();
  endtask

  task automatic test_single_owner;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || gnt_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt=%b busy=%b id=%0d, expected 0100/1/2", gnt, busy, gnt_id);
    end
    wr_en = 4'b0100;
    wr_data[2*W +: W] = 8'hC3;
    tick();
    checks++;
    if (q !== 8'hC3 || gnt !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_write: q=%h gnt=%b, expected c3/0100", q, gnt);
    end
    wr_en = '0;
    rel   = 4'b0100;
    tick();
    rel = '0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_cycle: gnt=%b busy=%b, expected 0000/0", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_gap: gnt=%b, expected 0000", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || q !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL lone_regrant: gnt=%b q=%h, expected 0100/c3", gnt, q);
    end
    settle();
  endtask

  task automatic test_rotation;
    logic [3:0] exp;
    pulse_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << (n % 4);
      tick();
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("[TB] FAIL rotation_%0d: gnt=%b, expected %b", n, gnt, exp);
      end
      rel = exp;
      tick();
      rel = '0;
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL rotation_gap1_%0d: gnt=%b, expected 0000", n, gnt);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL rotation_gap2_%0d: gnt=%b, expected 0000", n, gnt);
      end
    end
    settle();
  endtask

  task automatic test_non_owner;
    pulse_reset();
    req   = 4'b0010;
    tick();
    wr_en = 4'b0010;
    wr_data[1*W +: W] = 8'h3C;
    tick();
    checks++;
    if (gnt !== 4'b0010 || q !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL owner1_write: gnt=%b q=%h, expected 0010/3c", gnt, q);
    end
    req   = 4'b1010;
    wr_en = 4'b1000;
    rel   = 4'b1000;
    wr_data[3*W +: W] = 8'hFF;
    tick();
    checks++;
    if (gnt !== 4'b0010 || q !== 8'h3C || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL non_owner_isolation: gnt=%b q=%h busy=%b, expected 0010/3c/1", gnt, q, busy);
    end
    settle();
  endtask

  task automatic test_write_release;
    pulse_reset();
    req = 4'b0001;
    tick();
    wr_en = 4'b0001;
    rel   = 4'b0001;
    wr_data[0 +: W] = 8'h11;
    tick();
    checks++;
    if (q !== 8'h11 || gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_and_release: q=%h gnt=%b busy=%b, expected 11/0000/0", q, gnt, busy);
    end
    settle();
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("[TB] FAIL owner3_grant: gnt=%b id=%0d, expected 1000/3", gnt, gnt_id);
    end
    req = 4'b0000;
    wr_data = '1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h11) begin
      errors++;
      $display("[TB] FAIL req_drop: gnt=%b busy=%b q=%h, expected 0000/0/11", gnt, busy, q);
    end
    settle();
  endtask

  task automatic test_hold;
    int n;
    pulse_reset();
    req = 4'b0010;
    tick();
    n = 0;
    while (gnt === 4'b0010 && n < 30) begin
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_timeout_low: timeout=%b at cycle %0d, expected 0", timeout, n);
      end
      n++;
      tick();
    end
`ifdef HOLD_TIMEOUT_EN
    checks++;
    if (n != MAX_HOLD || timeout !== 1'b1 || gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL forced_release: held=%0d timeout=%b gnt=%b, expected %0d/1/0000",
               n, timeout, gnt, MAX_HOLD);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse_width: timeout=%b, expected 0", timeout);
    end
`else
    checks++;
    if (n != 30 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL indefinite_hold: held=%0d timeout=%b, expected 30/0", n, timeout);
    end
`endif
    settle();
  endtask

  task automatic test_random;
    logic [3:0] exp_gnt;
    pulse_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        req[i]   = ($urandom_range(0, 9) < 8);
        rel[i]   = ($urandom_range(0, 9) < 1);
        wr_en[i] = ($urandom_range(0, 9) < 4);
      end
      wr_data = $urandom;
      tick();
      model_step();
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if (gnt !== exp_gnt || busy !== (m_owner >= 0) || q !== m_q || timeout !== m_to ||
          (m_owner >= 0 && gnt_id !== 2'(m_owner))) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d: gnt=%b busy=%b id=%0d q=%h to=%b, expected %b/%0d/%0d/%h/%b",
                 c, gnt, busy, gnt_id, q, timeout, exp_gnt, (m_owner >= 0), m_owner, m_q, m_to);
      end
    end
    settle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    test_reset();
    test_reset_mid_grant();
    test_single_owner();
    test_rotation();
    test_non_owner();
    test_write_release();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
